// File: rtl/la_dft_pkg.sv
// Shared DFT definitions: scan-chain direction selectors, shift-counter state
// encoding and the counter-width helper used by scan register banks.
package la_dft_pkg;

    localparam bit LA_SCAN_LSB_IN = 1'b0;
    localparam bit LA_SCAN_MSB_IN = 1'b1;

    typedef enum logic {
        CNT_IDLE  = 1'b0,
        CNT_SHIFT = 1'b1
    } la_cnt_state_e;

    // Bits needed to count 0..width inclusive.
    function automatic int la_cntw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/la_sdffvec_cnt.sv
// Saturating scan-shift counter: counts consecutive se=1 edges up to MAX and
// raises a registered sfull once a full chain length has been shifted.
module la_sdffvec_cnt
    import la_dft_pkg::*;
#(
    parameter int MAX = 8,
    parameter int CW  = la_cntw(MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          se,
    output logic [CW-1:0] scnt,
    output logic          sfull
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    la_cnt_state_e state;
    la_cnt_state_e state_next;
    logic [CW-1:0] scnt_next;
    logic          sfull_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CNT_IDLE;
            scnt  <= '0;
            sfull <= 1'b0;
        end else begin
            state <= state_next;
            scnt  <= scnt_next;
            sfull <= sfull_next;
        end
    end

    always_comb begin
        state_next = state;
        scnt_next  = scnt;
        sfull_next = sfull;
        case (state)
            CNT_IDLE: begin
                if (se) begin
                    state_next = CNT_SHIFT;
                    scnt_next  = CW'(1);
                    sfull_next = (MAX_C == CW'(1));
                end else begin
                    scnt_next  = '0;
                    sfull_next = 1'b0;
                end
            end
            CNT_SHIFT: begin
                if (se) begin
                    // Hold at MAX so a long scan burst never wraps back to 0.
                    if (scnt != MAX_C) begin
                        scnt_next = scnt + CW'(1);
                    end
                    sfull_next = (scnt_next == MAX_C);
                end else begin
                    state_next = CNT_IDLE;
                    scnt_next  = '0;
                    sfull_next = 1'b0;
                end
            end
            default: begin
                state_next = CNT_IDLE;
                scnt_next  = '0;
                sfull_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/la_sdffvec.sv
// WIDTH-bit scan register bank: sync-reset D flops with load enable, one serial
// scan chain through every bit, and a saturating shift counter with full flag.
module la_sdffvec
    import la_dft_pkg::*;
#(
    parameter                   PROP   = "DEFAULT",
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] RSTVAL = {WIDTH{1'b0}},
    parameter bit               MSBIN  = LA_SCAN_LSB_IN,
    localparam int              CW     = la_cntw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             se,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic [CW-1:0]    scnt,
    output logic             sfull
);

    logic [WIDTH-1:0] chain;

    // Tech-mapping hook: non-default PROP values select a library cell elsewhere.
    if (PROP == "DEFAULT") begin : g_prop_default
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        if (MSBIN == LA_SCAN_MSB_IN) begin : g_msb_in
            if (i == WIDTH - 1) begin : g_head
                assign chain[i] = si;
            end else begin : g_link
                assign chain[i] = q[i+1];
            end
        end else begin : g_lsb_in
            if (i == 0) begin : g_head
                assign chain[i] = si;
            end else begin : g_link
                assign chain[i] = q[i-1];
            end
        end
    end

    // rst first so unknown se/en during reset cannot disturb the reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RSTVAL;
        end else if (se) begin
            q <= chain;
        end else if (en) begin
            q <= d;
        end
    end

    if (MSBIN == LA_SCAN_MSB_IN) begin : g_so_msb
        assign so = q[0];
    end else begin : g_so_lsb
        assign so = q[WIDTH-1];
    end

    la_sdffvec_cnt #(
        .MAX (WIDTH),
        .CW  (CW)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .se    (se),
        .scnt  (scnt),
        .sfull (sfull)
    );

endmodule
